i2s_rx: RTL and testbench

//  I2S slave receiver for an external ADC/codec (e.g. PCM1808) driving bck, lrck and data.

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_sync.sv | 41 ++++
 rtl/i2s_rx.sv | 169 ++++++++++++++++
 tb/tb_i2s_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S slave receiver.
//   i2s_state_e       receiver lock state (idle, seeking left-slot start, running)
//   I2S_CNT_W         width of the in-slot bit position counter
//   I2S_CNT_MAX       saturation value of that counter
//   I2S_DEFAULT_WIDTH default sample width
`timescale 1ns/1ps
package i2s_pkg;
    localparam int unsigned I2S_CNT_W = 6;
    localparam logic [I2S_CNT_W-1:0] I2S_CNT_MAX = 6'd63;
    localparam int unsigned I2S_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSeek,
        StRun
    } i2s_state_e;
endpackage

// File: rtl/i2s_sync.sv
// i2s_sync: multi-stage synchronizer for one asynchronous I2S pin, followed by a
// one-flop delay used for edge detection.
//   clk      sysclk
//   rst      asynchronous active-high reset
//   pin_i    raw asynchronous pin
//   level_o  synchronized pin level
//   rise_o   one-clk pulse on a synchronized 0->1 transition
//   fall_o   one-clk pulse on a synchronized 1->0 transition
`timescale 1ns/1ps
module i2s_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
        dly_d  = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~dly_q;
    assign fall_o  = ~level_o & dly_q;
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver. Oversamples bck/lrck/sdata in the sysclk domain and
// deserialises standard I2S frames (lrck low = left, MSB one bck after the lrck edge,
// data sampled on rising bck). Emits one left/right pair per frame with a strobe.
//   clk           sysclk (>= 4x bck)
//   rst           asynchronous active-high reset
//   bck/lrck/sdata  I2S pins from the ADC, asynchronous to clk
//   left/right    last complete sample pair
//   sample_valid  one-clk pulse when left/right update
//   frame_err     one-clk pulse on a short slot (I2S_RX_FRAME_CHECK_EN builds only)
//   locked        high while in the run state
// Optional feature macro: I2S_RX_FRAME_CHECK_EN -- short slots abort the frame and
// force a re-lock instead of being zero-padded.
`timescale 1ns/1ps
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH       = I2S_DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bck,
    input  logic             lrck,
    input  logic             sdata,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             sample_valid,
    output logic             frame_err,
    output logic             locked
);
    logic bck_s, bck_rise, bck_fall;
    logic lrck_s, lrck_rise, lrck_fall;
    logic sdata_s, sdata_rise, sdata_fall;

    i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bck (
        .clk(clk), .rst(rst), .pin_i(bck),
        .level_o(bck_s), .rise_o(bck_rise), .fall_o(bck_fall)
    );
    i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(clk), .rst(rst), .pin_i(lrck),
        .level_o(lrck_s), .rise_o(lrck_rise), .fall_o(lrck_fall)
    );
    i2s_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk(clk), .rst(rst), .pin_i(sdata),
        .level_o(sdata_s), .rise_o(sdata_rise), .fall_o(sdata_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{bck_s, bck_fall, lrck_rise, lrck_fall, sdata_rise, sdata_fall};

    i2s_state_e           state_q, state_d;
    logic                 lr_prev_q, lr_prev_d;
    logic [I2S_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [WIDTH-1:0]     left_hold_q, left_hold_d;
    logic [WIDTH-1:0]     left_q, left_d;
    logic [WIDTH-1:0]     right_q, right_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;

    logic [31:0]          cnt_ext;
    logic [WIDTH-1:0]     word;
    logic                 slot_end;

    assign cnt_ext  = 32'(cnt_q);
    assign slot_end = lrck_s != lr_prev_q;

    // Current shift contents with this rise's bit merged in; bits past WIDTH are dropped.
    always_comb begin
        word = shift_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_ext == WIDTH - 1 - i) word[i] = sdata_s;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic short_slot;
    assign short_slot = (cnt_ext + 32'd1) < WIDTH;
`endif

    always_comb begin
        state_d     = state_q;
        lr_prev_d   = lr_prev_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        if (bck_rise) begin
            lr_prev_d = lrck_s;
            if (slot_end) begin
                // Shift is cleared at slot start so a short slot pads its LSBs with 0.
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = word;
                if (cnt_q != I2S_CNT_MAX) cnt_d = cnt_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = StSeek;
                end
                StSeek: begin
                    // Right slot ending: the next bit is a left MSB.
                    if (slot_end && lr_prev_q && !lrck_s) state_d = StRun;
                end
                StRun: begin
                    if (slot_end) begin
`ifdef I2S_RX_FRAME_CHECK_EN
                        if (short_slot) begin
                            err_d   = 1'b1;
                            state_d = StSeek;
                        end else
`endif
                        if (!lr_prev_q) begin
                            left_hold_d = word;
                        end else begin
                            left_d  = left_hold_q;
                            right_d = word;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        locked_d = state_d == StRun;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            locked_q    <= locked_d;
        end
    end

    assign left         = left_q;
    assign right        = right_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign locked       = locked_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: self-checking bench for i2s_rx. An I2S source model drives bck/lrck/sdata;
// expected pairs go into a scoreboard queue as frames are driven and are popped when
// sample_valid fires.
`timescale 1ns/1ps
module tb_i2s_rx;
    localparam int unsigned W = 16;
    localparam int NRAND = 250;

    logic         clk, rst, bck, lrck, sdata;
    logic [W-1:0] left, right;
    logic         sample_valid, frame_err, locked;

    i2s_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bck(bck), .lrck(lrck), .sdata(sdata),
        .left(left), .right(right), .sample_valid(sample_valid),
        .frame_err(frame_err), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    typedef struct {
        int          l_len;
        int          r_len;
        logic [15:0] l;
        logic [15:0] r;
        logic        fill;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    pair_t        exp_q[$];
    vec_t         vecs[6];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           valid_cnt = 0;
    int           err_cnt = 0;
    int           half_ns = 40;
    logic [15:0]  prev_l = '0;
    logic [15:0]  prev_r = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe; outputs may only move with a strobe.
    always @(negedge clk) begin
        pair_t e;
        if (!rst) begin
            if (sample_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got left=%h right=%h, required no strobe",
                             left, right);
                end else begin
                    e = exp_q.pop_front();
                    check("left", 32'(left), 32'(e.l));
                    check("right", 32'(right), 32'(e.r));
                end
            end
            if (frame_err) err_cnt++;
            if (left != prev_l || right != prev_r) check("update_with_valid", 32'(sample_valid), 1);
        end
        prev_l = left;
        prev_r = right;
    end

    // lrck switches together with the LSB of the outgoing slot, as in standard I2S.
    task automatic drive_bit(input logic lr, input logic d);
        bck   = 1'b0;
        lrck  = lr;
        sdata = d;
        #(half_ns);
        bck = 1'b1;
        #(half_ns);
    endtask

    task automatic send_part(input logic ch, input int n, input int first, input int last,
                             input logic [15:0] w, input logic fill, input logic next_ch);
        for (int i = first; i <= last; i++) begin
            drive_bit((i == n - 1) ? next_ch : ch, (i < 16) ? w[15 - i] : fill);
        end
    endtask

    task automatic send_slot(input logic ch, input int n, input logic [15:0] w,
                             input logic fill, input logic next_ch);
        send_part(ch, n, 0, n - 1, w, fill, next_ch);
    endtask

    task automatic send_frame(input int l_len, input int r_len, input logic [15:0] l,
                              input logic [15:0] r, input logic fill);
        send_slot(1'b0, l_len, l, fill, 1'b1);
        send_slot(1'b1, r_len, r, fill, 1'b0);
    endtask

    task automatic settle();
        repeat (40) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int err0;
        logic [15:0] rl, rr;

        vecs[0] = '{16, 16, 16'hA55A, 16'h1234, 1'b0, 16'hA55A, 16'h1234};
        vecs[1] = '{16, 16, 16'hA55A, 16'h1234, 1'b0, 16'hA55A, 16'h1234};
        vecs[2] = '{32, 32, 16'h8001, 16'h1234, 1'b1, 16'h8001, 16'h1234};
        vecs[3] = '{32, 32, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF};
        vecs[4] = '{24, 24, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0001};
        vecs[5] = '{16, 16, 16'h5A5A, 16'hC3C3, 1'b0, 16'h5A5A, 16'hC3C3};

        rst = 1'b1; bck = 1'b0; lrck = 1'b1; sdata = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_left", 32'(left), 0);
        check("rst_right", 32'(right), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_locked", 32'(locked), 0);
        rst = 1'b0;

        // Table: first frame only locks, every following frame must be emitted.
        send_frame(16, 16, 16'hA55A, 16'h1234, 1'b0);
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back({vecs[k].exp_l, vecs[k].exp_r});
            send_frame(vecs[k].l_len, vecs[k].r_len, vecs[k].l, vecs[k].r, vecs[k].fill);
        end
        settle();
        check("locked_run", 32'(locked), 1);
        check("valid_count_table", 32'(valid_cnt), 6);

        // Reset mid-left-slot: the ones already shifted in must not leak into later words.
        send_part(1'b0, 16, 0, 7, 16'hFFFF, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_left", 32'(left), 0);
        check("midrst_right", 32'(right), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_valid", 32'(sample_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        send_part(1'b0, 16, 8, 15, 16'hFFFF, 1'b0, 1'b1);
        send_slot(1'b1, 16, 16'hFFFF, 1'b0, 1'b0);
        exp_q.push_back({16'h0F0F, 16'h00F0});
        send_frame(16, 16, 16'h0F0F, 16'h00F0, 1'b0);
        settle();

        // Start mid-right-slot: lock on the first 1->0 lrck, then the first full pair.
        reset_pulse();
        send_part(1'b1, 16, 9, 14, 16'hFFFF, 1'b0, 1'b0);
        check("seek_unlocked", 32'(locked), 0);
        send_part(1'b1, 16, 15, 15, 16'hFFFF, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("lock_on_lrck_fall", 32'(locked), 1);
        exp_q.push_back({16'h1357, 16'h2468});
        send_frame(16, 16, 16'h1357, 16'h2468, 1'b0);
        exp_q.push_back({16'hFEDC, 16'h0BA9});
        send_frame(16, 16, 16'hFEDC, 16'h0BA9, 1'b0);
        settle();

        // Short (12-bit) left slot.
        err0 = err_cnt;
`ifdef I2S_RX_FRAME_CHECK_EN
        send_slot(1'b0, 12, 16'hBEEF, 1'b0, 1'b1);
        send_part(1'b1, 16, 0, 3, 16'h4321, 1'b0, 1'b0);
        check("short_err", 32'(err_cnt - err0), 1);
        check("short_unlocked", 32'(locked), 0);
        send_part(1'b1, 16, 4, 15, 16'h4321, 1'b0, 1'b0);
`else
        exp_q.push_back({16'hBEE0, 16'h4321});
        send_slot(1'b0, 12, 16'hBEEF, 1'b0, 1'b1);
        send_part(1'b1, 16, 0, 3, 16'h4321, 1'b0, 1'b0);
        check("short_err", 32'(err_cnt - err0), 0);
        check("short_locked", 32'(locked), 1);
        send_part(1'b1, 16, 4, 15, 16'h4321, 1'b0, 1'b0);
`endif
        exp_q.push_back({16'h6789, 16'h9876});
        send_frame(16, 16, 16'h6789, 16'h9876, 1'b0);
        settle();
        check("relocked", 32'(locked), 1);

        // Random bck period and phase against clk, random data.
        reset_pulse();
        valid_cnt = 0;
        #($urandom_range(1, 9));
        for (int f = 0; f < NRAND; f++) begin
            half_ns = $urandom_range(21, 26);
            rl = 16'($urandom);
            rr = 16'($urandom);
            if (f > 0) exp_q.push_back({rl, rr});
            send_frame(16, 16, rl, rr, 1'b0);
        end
        settle();
        check("valid_count_random", 32'(valid_cnt), NRAND - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
